pu_ex_md: RTL

//  Multi-cycle multiply/divide sequencer for the PU EX stage; owns the HI/LO registers.

---
 rtl/pu_ex_md.sv | 111 +++++++++++
 1 files changed

// File: rtl/pu_ex_md.sv
// pu_ex_md: multi-cycle multiply/divide sequencer owning the HI/LO registers
module pu_ex_md #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
    localparam logic [DATA_W-1:0] ONE = 1;
    localparam logic [2*DATA_W-1:0] ONE2 = 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t              state, state_d;
    logic [2*DATA_W-1:0] acc, mul_n, div_n, prod;
    logic [DATA_W-1:0]   b, ma, mb, rem_n, q, r;
    logic [DATA_W:0]     sum, u;
    logic [CW-1:0]       cnt;
    logic                neg_q, neg_r, is_div, sgn, dz, go, ge;

    function automatic logic [DATA_W-1:0] neg(input logic [DATA_W-1:0] x);
        return ~x + ONE;
    endfunction

    assign busy  = (state != IDLE);
    assign sgn   = ~op[0];
    assign dz    = (in1 == '0);
    assign go    = start && !flush && (state == IDLE);
    assign ma    = (sgn && in0[DATA_W-1]) ? neg(in0) : in0;
    assign mb    = (sgn && in1[DATA_W-1]) ? neg(in1) : in1;
    // shift-add step: multiplier bits sit in the low half and shift out as the product shifts in
    assign sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, b} : '0);
    assign mul_n = {sum, acc[DATA_W-1:1]};
    // restoring step: shifted partial remainder is one bit wider than the divisor
    assign u     = acc[2*DATA_W-1:DATA_W-1];
    assign ge    = (u >= {1'b0, b});
    assign rem_n = ge ? (u[DATA_W-1:0] - b) : u[DATA_W-1:0];
    assign div_n = {rem_n, acc[DATA_W-2:0], ge};
    assign prod  = neg_q ? (~acc + ONE2) : acc;
    assign q     = acc[DATA_W-1:0];
    assign r     = acc[2*DATA_W-1:DATA_W];

    // state register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    // next-state: divide by zero skips iteration, flush always returns to idle
    always_comb begin
        state_d = state;
        case (state)
            IDLE:     if (go && !op[2]) state_d = op[1] ? (dz ? FIX : DIV) : MUL;
            MUL, DIV: if (cnt == LAST) state_d = FIX;
            default:  state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // datapath: operand latch, iteration, sign fix-up and HI/LO writeback
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi     <= '0;
            lo     <= '0;
            acc    <= '0;
            b      <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_div <= 1'b0;
        end else begin
            done <= 1'b0;
            cnt  <= '0;
            if (go && op == 3'd4) begin
                hi   <= in0;
                done <= 1'b1;
            end
            if (go && op == 3'd5) begin
                lo   <= in0;
                done <= 1'b1;
            end
            if (go && !op[2]) begin
                is_div <= op[1];
                neg_q  <= sgn && !(op[1] && dz) && (in0[DATA_W-1] ^ in1[DATA_W-1]);
                neg_r  <= sgn && !(op[1] && dz) && in0[DATA_W-1];
                b      <= op[1] ? mb : ma;
                acc    <= (op[1] && dz) ? {in0, {DATA_W{1'b1}}} : {{DATA_W{1'b0}}, op[1] ? ma : mb};
            end
            if (!flush && (state == MUL || state == DIV)) begin
                acc <= (state == MUL) ? mul_n : div_n;
                cnt <= cnt + CW'(1);
            end
            if (!flush && state == FIX) begin
                hi   <= is_div ? (neg_r ? neg(r) : r) : prod[2*DATA_W-1:DATA_W];
                lo   <= is_div ? (neg_q ? neg(q) : q) : prod[DATA_W-1:0];
                done <= 1'b1;
            end
        end
    end
endmodule
